// File: rtl/simeck_decrypt_top.sv
// Sequential Simeck decryptor: expands the key forward into a round-key
// buffer, then runs the inverse rounds in reverse key order.
module simeck_decrypt_top #(
  parameter int DDATAW = 20,
  parameter int ROUNDS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DDATAW-1:0]     Data,
  input  logic [2*DDATAW-1:0]   Key,
  output logic                  busy,
  output logic                  done,
  output logic [DDATAW-1:0]     plaintext
);

  localparam int N  = DDATAW / 2;
  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(ROUNDS - 1);
  // 2^N - 4: all ones except the two low bits
  localparam logic [N-1:0] C_CONST = {{(N-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {S_IDLE, S_KEYGEN, S_DECRYPT} state_t;

  // Simeck round function f(x) = (x & rotl(x,5)) ^ rotl(x,1)
  function automatic logic [N-1:0] f_fn(input logic [N-1:0] x);
    logic [N-1:0] r1;
    logic [N-1:0] r5;
    r1 = {x[N-2:0], x[N-1]};
    r5 = {x[N-6:0], x[N-1:N-5]};
    return (x & r5) ^ r1;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      lfsr_q, lfsr_d;
  logic [N-1:0]    t2_q, t2_d, t1_q, t1_d, t0_q, t0_d, key_q, key_d;
  logic [N-1:0]    l_q, l_d, r_q, r_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DDATAW-1:0] pt_q, pt_d;

  logic [N-1:0]    rk_mem [ROUNDS];
  logic            rk_we;
  logic [N-1:0]    rk_rd;
  logic [N-1:0]    r_new;

  assign rk_rd = rk_mem[cnt_q];
  assign r_new = l_q ^ f_fn(r_q) ^ rk_rd;

  // Next-state logic: latch on start, expand keys, then peel rounds off
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    t2_d    = t2_q;
    t1_d    = t1_q;
    t0_d    = t0_q;
    key_d   = key_q;
    l_d     = l_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pt_d    = pt_q;
    rk_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          t2_d    = Key[4*N-1:3*N];
          t1_d    = Key[3*N-1:2*N];
          t0_d    = Key[2*N-1:N];
          key_d   = Key[N-1:0];
          l_d     = Data[DDATAW-1:N];
          r_d     = Data[N-1:0];
          cnt_d   = '0;
          lfsr_d  = 5'b11111;
          busy_d  = 1'b1;
          state_d = S_KEYGEN;
        end
      end
      S_KEYGEN: begin
        rk_we  = 1'b1;
        key_d  = t0_q;
        t0_d   = t1_q;
        t1_d   = t2_q;
        t2_d   = key_q ^ f_fn(t0_q) ^ C_CONST ^ {{(N-1){1'b0}}, lfsr_q[0]};
        // x^5 + x^2 + 1: s[i+5] = s[i+2] ^ s[i]
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2], lfsr_q[4:1]};
        if (cnt_q == LAST_IDX) begin
          state_d = S_DECRYPT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECRYPT: begin
        l_d = r_q;
        r_d = r_new;
        if (cnt_q == '0) begin
          pt_d    = {r_q, r_new};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= 5'b11111;
      t2_q    <= '0;
      t1_q    <= '0;
      t0_q    <= '0;
      key_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      t2_q    <= t2_d;
      t1_q    <= t1_d;
      t0_q    <= t0_d;
      key_q   <= key_d;
      l_q     <= l_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pt_q    <= pt_d;
    end
  end

  // Round-key buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (rk_we) begin
      rk_mem[cnt_q] <= key_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign plaintext = pt_q;

endmodule

// File: tb/tb_simeck_decrypt_top.sv
// Directed bench for simeck_decrypt_top with a behavioural Simeck model.
module tb_simeck_decrypt_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start1;
  logic [19:0] data, data1;
  logic [39:0] key, key1;
  logic        busy, done, busy1, done1;
  logic [19:0] plaintext, plaintext1;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  logic [9:0] mrk [32];

  simeck_decrypt_top #(.DDATAW(20), .ROUNDS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .Data(data), .Key(key),
    .busy(busy), .done(done), .plaintext(plaintext)
  );

  simeck_decrypt_top #(.DDATAW(20), .ROUNDS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .Data(data1), .Key(key1),
    .busy(busy1), .done(done1), .plaintext(plaintext1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  function automatic logic [9:0] rl(input logic [9:0] x, input int s);
    return 10'((x << s) | (x >> (10 - s)));
  endfunction

  function automatic logic [9:0] ff(input logic [9:0] x);
    return (x & rl(x, 5)) ^ rl(x, 1);
  endfunction

  task automatic build_keys(input logic [39:0] k);
    logic [9:0] t2, t1, t0, kk, nt2;
    logic [4:0] lf;
    t2 = k[39:30]; t1 = k[29:20]; t0 = k[19:10]; kk = k[9:0]; lf = 5'h1f;
    for (int i = 0; i < 32; i++) begin
      mrk[i] = kk;
      nt2 = kk ^ ff(t0) ^ 10'h3FC ^ {9'b0, lf[0]};
      kk = t0; t0 = t1; t1 = t2; t2 = nt2;
      lf = {lf[0] ^ lf[2], lf[4:1]};
    end
  endtask

  task automatic model_enc(input logic [19:0] p, input logic [39:0] k, output logic [19:0] c);
    logic [9:0] l, r, nl;
    build_keys(k);
    l = p[19:10]; r = p[9:0];
    for (int i = 0; i < 32; i++) begin
      nl = r ^ ff(l) ^ mrk[i];
      r = l; l = nl;
    end
    c = {l, r};
  endtask

  task automatic model_dec(input logic [19:0] c, input logic [39:0] k, output logic [19:0] p);
    logic [9:0] l, r, nr;
    build_keys(k);
    l = c[19:10]; r = c[9:0];
    for (int i = 31; i >= 0; i--) begin
      nr = l ^ ff(r) ^ mrk[i];
      l = r; r = nr;
    end
    p = {l, r};
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a start pulse; returns at the negedge after the accepting edge
  task automatic do_start(input logic [19:0] d, input logic [39:0] k);
    data = d; key = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Step negedges until done (bounded); counts busy-high samples
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, ds;
    logic [19:0] ct, exp_a, exp_b, exp_p;

    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    data = '0; key = '0; data1 = '0; key1 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("idle_pt", 64'(plaintext), 64'h0);
      @(negedge clk);
    end
    $display("txn reset_idle done");

    // Round trip through the model encryptor
    model_enc(20'hABCDE, 40'h0123456789, ct);
    do_start(ct, 40'h0123456789);
    wait_done(lat, bcnt);
    $display("txn roundtrip ct=%h lat=%0d pt=%h", ct, lat, plaintext);
    check("rt_latency", 64'(lat), 64'd64);
    check("rt_busy_cycles", 64'(bcnt), 64'd64);
    check("rt_busy_at_done", 64'(busy), 64'd0);
    check("rt_plaintext", 64'(plaintext), 64'hABCDE);
    @(negedge clk);
    check("rt_done_pulse", 64'(done), 64'd0);
    check("rt_pt_held", 64'(plaintext), 64'hABCDE);

    // Golden vectors: all zeros and all ones
    model_dec(20'h00000, 40'h0000000000, exp_p);
    do_start(20'h00000, 40'h0000000000);
    wait_done(lat, bcnt);
    $display("txn golden0 lat=%0d pt=%h", lat, plaintext);
    check("g0_latency", 64'(lat), 64'd64);
    check("g0_plaintext", 64'(plaintext), 64'(exp_p));
    @(negedge clk);
    check("g0_done_pulse", 64'(done), 64'd0);

    model_dec(20'hFFFFF, 40'hFFFFFFFFFF, exp_p);
    do_start(20'hFFFFF, 40'hFFFFFFFFFF);
    wait_done(lat, bcnt);
    $display("txn golden1 lat=%0d pt=%h", lat, plaintext);
    check("g1_latency", 64'(lat), 64'd64);
    check("g1_plaintext", 64'(plaintext), 64'(exp_p));
    @(negedge clk);
    check("g1_done_pulse", 64'(done), 64'd0);

    // Start while busy with changed inputs must be ignored
    model_dec(20'h13579, 40'h2468ACE013, exp_p);
    ds = done_seen;
    do_start(20'h13579, 40'h2468ACE013);
    repeat (10) @(negedge clk);
    data = 20'h55555; key = 40'hAAAAAAAAAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    lat = lat + 11;
    $display("txn busy_start lat=%0d pt=%h", lat, plaintext);
    check("bs_latency", 64'(lat), 64'd64);
    check("bs_plaintext", 64'(plaintext), 64'(exp_p));
    repeat (70) @(negedge clk);
    check("bs_single_done", 64'(done_seen - ds), 64'd1);

    // Reset mid-operation aborts without a done pulse
    ds = done_seen;
    do_start(20'h2B3C4, 40'h1122334455);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pt", 64'(plaintext), 64'h0);
    repeat (80) @(negedge clk);
    check("rst_no_done", 64'(done_seen - ds), 64'd0);
    model_dec(20'h2B3C4, 40'h1122334455, exp_p);
    do_start(20'h2B3C4, 40'h1122334455);
    wait_done(lat, bcnt);
    $display("txn after_reset lat=%0d pt=%h", lat, plaintext);
    check("ar_latency", 64'(lat), 64'd64);
    check("ar_plaintext", 64'(plaintext), 64'(exp_p));
    @(negedge clk);

    // Back-to-back: second start in the done cycle
    model_dec(20'h12345, 40'hFEDCBA9876, exp_a);
    model_dec(20'h0F0F0, 40'h13579BDF02, exp_b);
    do_start(20'h12345, 40'hFEDCBA9876);
    wait_done(lat, bcnt);
    $display("txn b2b_first lat=%0d pt=%h", lat, plaintext);
    check("b2b_a_latency", 64'(lat), 64'd64);
    check("b2b_a_pt", 64'(plaintext), 64'(exp_a));
    do_start(20'h0F0F0, 40'h13579BDF02);
    repeat (32) @(negedge clk);
    check("b2b_a_held", 64'(plaintext), 64'(exp_a));
    check("b2b_busy_mid", 64'(busy), 64'd1);
    wait_done(lat, bcnt);
    lat = lat + 32;
    $display("txn b2b_second lat=%0d pt=%h", lat, plaintext);
    check("b2b_b_latency", 64'(lat), 64'd64);
    check("b2b_b_pt", 64'(plaintext), 64'(exp_b));
    @(negedge clk);

    // ROUNDS=1: result is {R, L ^ f(R) ^ k0}; with Data=0, k0=0x155 -> 0x00155
    data1 = 20'h00000; key1 = 40'h0000000155; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("r1_busy0", 64'(busy1), 64'd1);
    check("r1_done0", 64'(done1), 64'd0);
    @(negedge clk);
    check("r1_done1", 64'(done1), 64'd0);
    @(negedge clk);
    $display("txn rounds1 done=%0d pt=%h", done1, plaintext1);
    check("r1_done2", 64'(done1), 64'd1);
    check("r1_pt", 64'(plaintext1), 64'h00155);
    check("r1_busy2", 64'(busy1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simeck_decrypt_top.md
Name: simeck_decrypt_top

Overview:
- Sequential Simeck decryptor: the inverse of the team's encrypt path, with the same word split, key layout and round function.
- Accepts a DDATAW-bit ciphertext and a 2*DDATAW-bit key under a start/busy/done handshake and returns the plaintext.
- Runs the key schedule forward into an internal round-key buffer, then applies the inverse rounds in reverse key order.
- Sits beside encrypt_top; a bench round-trip through both must return the original Data.

Parameters:
- DDATAW, 20: block width; word width N = DDATAW/2; DDATAW must be even and N >= 6.
- ROUNDS, 32: round count; round-key buffer depth; must match the encryptor.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  request; sampled only in IDLE
- Data  input  DDATAW  ciphertext {L,R}; L = Data[DDATAW-1:N]
- Key  input  2*DDATAW  {k3,k2,k1,k0}; k0 = Key[N-1:0]
- busy  output  1  high in KEYGEN/DECRYPT
- done  output  1  one-cycle pulse when plaintext is valid
- plaintext  output  DDATAW  result {L,R}; held until the next completion

Behaviour:
- Arithmetic (all on N bits):
  - rotl(x,s) is an N-bit rotate left.
  - f(x) = (x & rotl(x,5)) ^ rotl(x,1).
  - C = 2^N - 4.
- Constant sequence:
  - 5-bit LFSR, seed 5'b11111, feedback x^5+x^2+1.
  - z_i is the LSB before step i.
  - LFSR reseeds at every accepted start.
- Key schedule, initial state t2=k3, t1=k2, t0=k1, key=k0.
- Per KEYGEN cycle i:
  - store rk[i] = key.
  - new key = t0.
  - t0 <= t1, t1 <= t2.
  - t2 <= key ^ f(t0) ^ C ^ z_i.
- Inverse round using rk[i], with state (L,R):
  - L' = R.
  - R' = L ^ f(R) ^ rk[i].
- FSM states: IDLE, KEYGEN, DECRYPT.
  - IDLE: start=1 at edge E0 -> latch Data and Key, clear the round counter, reseed the LFSR, go to KEYGEN. busy goes high the cycle after E0.
  - KEYGEN: ROUNDS cycles (E1..E_ROUNDS) writing rk[0..ROUNDS-1]. On the last write, go to DECRYPT with counter = ROUNDS-1.
  - DECRYPT: ROUNDS cycles (E_ROUNDS+1..E_2*ROUNDS) applying rk[counter], counter decrementing. At counter 0: load plaintext with the result, set done=1 for exactly one cycle, clear busy, return to IDLE.
- Latency: done is high in the cycle following edge E_2*ROUNDS, i.e. 2*ROUNDS cycles after the start edge.
- The round-key buffer is register- or RAM-inferred. Read-before-write hazards do not arise because KEYGEN completes before DECRYPT begins.
- start while busy: ignored; in-flight inputs are latched, so changes to Data/Key mid-operation have no effect.
- Back-to-back: start in the same cycle done is high is accepted (FSM is already in IDLE).
- Reset:
  - Values: busy=0, done=0, plaintext=0, state IDLE, counter 0, LFSR = 5'b11111.
  - Reset wins over a simultaneous start.
  - Reset mid-operation aborts with no done pulse; the buffer contents need not be cleared.
- ROUNDS=1 edge case: one KEYGEN cycle, one DECRYPT cycle, done after 2 cycles.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, start=0 -> busy=0, done=0, plaintext=20'h0 for 10 cycles.
- Round trip: encrypt_top with Data=20'hABCDE, Key=40'h0123456789 produces C; feed C and the same Key with start=1 -> done after exactly 64 cycles, plaintext=20'hABCDE, busy high for 64 cycles.
- Golden model:
  - Data=20'h00000, Key=40'h0000000000 and Data=20'hFFFFF, Key=40'hFFFFFFFFFF.
  - plaintext must equal the bench Python/SV model built from the Behaviour equations.
  - done must be a single-cycle pulse.
- Start while busy plus input change: start at cycle 0, start pulse and new Data/Key at cycle 10 -> exactly one done at cycle 64, result for the original inputs.
- Reset mid-operation: start, then reset at cycle 40 -> no done, busy=0 next cycle, plaintext=0. A fresh start afterwards produces the correct result with full 64-cycle latency.
- Back-to-back: second start asserted in the done cycle -> second done exactly 64 cycles later. First plaintext is held until then, then replaced.
